// File: rtl/alu_pkg.sv
// Shared definitions for the operand-capture front end and the ALU:
// FSM state encoding, push-button indices and the default debounce length.
package alu_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // Capture FSM state encoding (also shown on the debug LEDs)
  localparam logic [1:0] ESPERA_A  = 2'd0;
  localparam logic [1:0] ESPERA_B  = 2'd1;
  localparam logic [1:0] ESPERA_OP = 2'd2;
  localparam logic [1:0] EMITE     = 2'd3;

  // Push-button indices inside the btn bus
  localparam int BTN_L   = 0;
  localparam int BTN_C   = 1;
  localparam int BTN_U   = 2;
  localparam int BTN_D   = 3;
  localparam int BTN_R   = 4;
  localparam int NUM_BTN = 5;

endpackage

// File: rtl/antirrebote.sv
// Single-button conditioning: 2-FF synchroniser, counting debouncer and
// rising-edge detector producing a one-cycle press pulse.
module antirrebote
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          prev_r;
  logic [CW-1:0] cnt_r;

  // Synchroniser keeps sampling even while the design is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else if (ena) begin
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_MAX) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Previous debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else if (ena) begin
      prev_r <= level_r;
    end
  end

  // One pulse per debounced 0->1 transition; nothing while disabled
  assign press = ena & level_r & ~prev_r;

endmodule

// File: rtl/captura_operandos.sv
// Operand-capture stage ahead of the ALU: conditions the five buttons and
// latches A, B and the opcode from sw, then requests the ALU via valid/ready.
module captura_operandos
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sw,
  input  logic [4:0] btn,
  output logic [7:0] a_o,
  output logic [7:0] b_o,
  output logic [3:0] op_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [1:0] state_o
);

  logic [NUM_BTN-1:0] press_s;

  logic [1:0] state_r, state_s;
  logic [7:0] a_r, a_s;
  logic [7:0] b_r, b_s;
  logic [3:0] op_r, op_s;
  logic       prev_ok_r, prev_ok_s;
  logic       valid_r, valid_s;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .btn  (btn[i]),
      .press(press_s[i])
    );
  end

  // Next-state and capture decisions; C beats D beats the per-state load
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    op_s      = op_r;
    prev_ok_s = prev_ok_r;
    if (ena) begin
      if (press_s[BTN_C]) begin
        state_s   = ESPERA_A;
        a_s       = 8'd0;
        b_s       = 8'd0;
        op_s      = 4'd0;
        prev_ok_s = 1'b0;
      end else begin
        case (state_r)
          ESPERA_A: begin
            if (press_s[BTN_D] && prev_ok_r) begin
              state_s = EMITE;
            end else if (press_s[BTN_L]) begin
              a_s     = sw;
              state_s = ESPERA_B;
            end else begin
              state_s = ESPERA_A;
            end
          end
          ESPERA_B: begin
            if (press_s[BTN_R]) begin
              b_s     = sw;
              state_s = ESPERA_OP;
            end else begin
              state_s = ESPERA_B;
            end
          end
          ESPERA_OP: begin
            if (press_s[BTN_U]) begin
              op_s    = sw[3:0];
              state_s = EMITE;
            end else begin
              state_s = ESPERA_OP;
            end
          end
          EMITE: begin
            // valid_r is always high here, so ready alone completes the handshake
            if (ready_i) begin
              prev_ok_s = 1'b1;
              state_s   = ESPERA_A;
            end else begin
              state_s = EMITE;
            end
          end
          default: begin
            state_s = ESPERA_A;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
    valid_s = (state_s == EMITE);
  end

  // FSM, operand and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ESPERA_A;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      op_r      <= 4'd0;
      prev_ok_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      op_r      <= op_s;
      prev_ok_r <= prev_ok_s;
      valid_r   <= valid_s;
    end
  end

  assign a_o     = a_r;
  assign b_o     = b_r;
  assign op_o    = op_r;
  assign valid_o = valid_r;
  assign state_o = state_r;

endmodule
